// File: rtl/peripheral_pkg.sv
// Shared register map and control-field layout for the peripheral timer bank.
// Channels sit at a 16-byte stride from 0x00; global registers live at 0x40+.
package peripheral_pkg;

  localparam int CH_STRIDE = 16;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_PSC  = 4'h4;
  localparam logic [3:0] REG_CMP  = 4'h8;
  localparam logic [3:0] REG_CNT  = 4'hC;

  localparam logic [6:0] REG_STATUS = 7'h40;
  localparam logic [6:0] REG_IRQEN  = 7'h44;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_TOGGLE  = 2;

  localparam logic [6:0] CH_MASK = 7'(~(CH_STRIDE - 1));

  typedef struct packed {
    logic toggle;
    logic oneshot;
    logic en;
  } ctrl_t;

  function automatic logic [6:0] ch_base(input int ch);
    return 7'(ch * CH_STRIDE);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, 32-bit counter, compare, toggle output, match pulse.
// Register writes land on the next edge; match_o is a same-cycle pulse for the top's STATUS.
module timer_channel
  import peripheral_pkg::*;
#(
  parameter int PSC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ctrl_we_i,
  input  logic             psc_we_i,
  input  logic             cmp_we_i,
  input  logic             cnt_we_i,
  input  logic [31:0]      wd_i,
  output ctrl_t            ctrl_o,
  output logic [PSC_W-1:0] psc_o,
  output logic [31:0]      cmp_o,
  output logic [31:0]      cnt_o,
  output logic             tout_o,
  output logic             match_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [31:0]      cmp_q, cmp_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic             tick;
  logic             match;

  always_comb begin
    tick  = ctrl_q.en && (psc_cnt_q == psc_q);
    // A CNT write in the same cycle suppresses the match entirely.
    match = tick && (cnt_q == cmp_q) && !cnt_we_i;

    ctrl_d = ctrl_q;
    if (ctrl_we_i) begin
      ctrl_d.en      = wd_i[CTRL_EN];
      ctrl_d.oneshot = wd_i[CTRL_ONESHOT];
      ctrl_d.toggle  = wd_i[CTRL_TOGGLE];
    end else if (match && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end

    psc_d = psc_we_i ? wd_i[PSC_W-1:0] : psc_q;
    cmp_d = cmp_we_i ? wd_i : cmp_q;

    psc_cnt_d = psc_cnt_q;
    if (cnt_we_i || (ctrl_we_i && wd_i[CTRL_EN] && !ctrl_q.en)) begin
      psc_cnt_d = '0;
    end else if (ctrl_q.en) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
    end

    cnt_d = cnt_q;
    if (cnt_we_i) begin
      cnt_d = wd_i;
    end else if (tick) begin
      cnt_d = (cnt_q == cmp_q) ? 32'd0 : cnt_q + 32'd1;
    end

    tout_d = tout_q ^ (match && ctrl_q.toggle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      cmp_q     <= '0;
      cnt_q     <= '0;
      tout_q    <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign psc_o   = psc_q;
  assign cmp_o   = cmp_q;
  assign cnt_o   = cnt_q;
  assign tout_o  = tout_q;
  assign match_o = match;

endmodule

// File: rtl/peripheral_timer_bank.sv
// Bank of N_CH prescaled compare timers with W1C match STATUS, IRQEN mask and level irq.
// RD is combinational from A; writes take effect on the next edge; irq lags STATUS by one cycle.
module peripheral_timer_bank
  import peripheral_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PSC_W = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      A,
  input  logic [31:0]     WD,
  input  logic            WE,
  output logic [31:0]     RD,
  output logic [N_CH-1:0] tout,
  output logic            irq
);

  ctrl_t            ch_ctrl [N_CH];
  logic [PSC_W-1:0] ch_psc  [N_CH];
  logic [31:0]      ch_cmp  [N_CH];
  logic [31:0]      ch_cnt  [N_CH];
  logic [N_CH-1:0]  ch_match;

  logic [N_CH-1:0]  status_q, status_d, status_clr;
  logic [N_CH-1:0]  irqen_q, irqen_d;
  logic             irq_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic ch_sel;
    assign ch_sel = WE && ((A & CH_MASK) == ch_base(g));

    timer_channel #(.PSC_W(PSC_W)) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ctrl_we_i (ch_sel && (A[3:0] == REG_CTRL)),
      .psc_we_i  (ch_sel && (A[3:0] == REG_PSC)),
      .cmp_we_i  (ch_sel && (A[3:0] == REG_CMP)),
      .cnt_we_i  (ch_sel && (A[3:0] == REG_CNT)),
      .wd_i      (WD),
      .ctrl_o    (ch_ctrl[g]),
      .psc_o     (ch_psc[g]),
      .cmp_o     (ch_cmp[g]),
      .cnt_o     (ch_cnt[g]),
      .tout_o    (tout[g]),
      .match_o   (ch_match[g])
    );
  end

  always_comb begin
    status_clr = '0;
    if (WE && (A == REG_STATUS)) status_clr = WD[N_CH-1:0];
    // Hardware set has priority over a coincident software clear.
    status_d = (status_q & ~status_clr) | ch_match;
    irqen_d  = (WE && (A == REG_IRQEN)) ? WD[N_CH-1:0] : irqen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      irqen_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irqen_q  <= irqen_d;
      irq_q    <= |(status_q & irqen_q);
    end
  end

  always_comb begin
    RD = '0;
    if (A == REG_STATUS) RD[N_CH-1:0] = status_q;
    if (A == REG_IRQEN)  RD[N_CH-1:0] = irqen_q;
    for (int i = 0; i < N_CH; i++) begin
      if ((A & CH_MASK) == ch_base(i)) begin
        case (A[3:0])
          REG_CTRL: RD[2:0]       = ch_ctrl[i];
          REG_PSC:  RD[PSC_W-1:0] = ch_psc[i];
          REG_CMP:  RD            = ch_cmp[i];
          REG_CNT:  RD            = ch_cnt[i];
          default:  ;
        endcase
      end
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_peripheral_timer_bank.sv
// Directed bench for peripheral_timer_bank: event-level reference model checked every cycle
// plus literal expectations for the headline timing scenarios and an N_CH=2 build.
module tb_peripheral_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  A = '0, A2 = '0;
  logic [31:0] WD = '0, WD2 = '0;
  logic        WE = 1'b0, WE2 = 1'b0;
  logic [31:0] RD, RD2;
  logic [3:0]  tout;
  logic [1:0]  tout2;
  logic        irq, irq2;

  int n_chk = 0;
  int n_fail = 0;

  bit          started = 1'b0;
  bit          lit_chk = 1'b0;
  int          lit_sel = 0;
  logic [31:0] lit_val = '0;
  string       lit_name = "";

  peripheral_timer_bank #(.N_CH(4), .PSC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .WD(WD), .WE(WE), .RD(RD), .tout(tout), .irq(irq)
  );

  peripheral_timer_bank #(.N_CH(2), .PSC_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .A(A2), .WD(WD2), .WE(WE2), .RD(RD2), .tout(tout2), .irq(irq2)
  );

  initial forever #5 clk = ~clk;

  // Reference model: each channel counts elapsed cycles in its prescale period;
  // a period completes after PSC+1 enabled cycles and advances the counter.
  bit [2:0]    m_ctrl [4];
  int unsigned m_psc [4];
  bit [31:0]   m_cmp [4];
  bit [31:0]   m_cnt [4];
  int unsigned m_elapsed [4];
  bit [3:0]    m_status, m_irqen, m_tout;
  bit          m_irq;

  task automatic model_step();
    bit [3:0] set = '0;
    bit [3:0] w1c = '0;
    bit [3:0] st_old = m_status;
    bit [3:0] ie_old = m_irqen;
    bit       ch_wr = WE && !A[6] && (A[1:0] == 2'b00);
    int       wc = int'(A[5:4]);
    int       wr = int'(A[3:2]);
    for (int c = 0; c < 4; c++) begin
      bit mine   = ch_wr && (wc == c);
      bit old_en = m_ctrl[c][0];
      if (old_en && !(mine && wr == 3)) begin
        m_elapsed[c]++;
        if (m_elapsed[c] == m_psc[c] + 1) begin
          m_elapsed[c] = 0;
          if (m_cnt[c] == m_cmp[c]) begin
            m_cnt[c] = '0;
            set[c]   = 1'b1;
            if (m_ctrl[c][2]) m_tout[c] = ~m_tout[c];
            if (m_ctrl[c][1]) m_ctrl[c][0] = 1'b0;
          end else begin
            m_cnt[c] = m_cnt[c] + 32'd1;
          end
        end
      end
      if (mine) begin
        case (wr)
          0: begin
            m_ctrl[c] = WD[2:0];
            if (WD[0] && !old_en) m_elapsed[c] = 0;
          end
          1: m_psc[c] = WD & 32'h00FF_FFFF;
          2: m_cmp[c] = WD;
          default: begin
            m_cnt[c]     = WD;
            m_elapsed[c] = 0;
          end
        endcase
      end
    end
    if (WE && A == 7'h40) w1c = WD[3:0];
    if (WE && A == 7'h44) m_irqen = WD[3:0];
    m_status = (st_old & ~w1c) | set;
    m_irq    = |(st_old & ie_old);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_ctrl[c] = '0; m_psc[c] = 0; m_cmp[c] = '0; m_cnt[c] = '0; m_elapsed[c] = 0;
      end
      m_status = '0; m_irqen = '0; m_tout = '0; m_irq = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic logic [31:0] m_read(input logic [6:0] a);
    int c = int'(a[5:4]);
    if (a == 7'h40) return {28'd0, m_status};
    if (a == 7'h44) return {28'd0, m_irqen};
    if (a[6] || a[1:0] != 2'b00) return '0;
    case (a[3:2])
      2'd0:    return {29'd0, m_ctrl[c]};
      2'd1:    return m_psc[c];
      2'd2:    return m_cmp[c];
      default: return m_cnt[c];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_rd", RD, m_read(A));
      chk("model_tout", 32'(tout), 32'(m_tout));
      chk("model_irq", 32'(irq), 32'(m_irq));
      if (lit_chk) begin
        case (lit_sel)
          0:       chk(lit_name, RD, lit_val);
          1:       chk(lit_name, 32'(tout), lit_val);
          2:       chk(lit_name, 32'(irq), lit_val);
          3:       chk(lit_name, RD2, lit_val);
          4:       chk(lit_name, 32'({tout, irq}), lit_val);
          default: chk(lit_name, 32'({tout2, irq2}), lit_val);
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    tick(1);
    WE = 1'b0;
  endtask

  task automatic wr2(input logic [6:0] a, input logic [31:0] d);
    A2 = a; WD2 = d; WE2 = 1'b1;
    tick(1);
    WE2 = 1'b0;
  endtask

  task automatic ex(input int sel, input logic [6:0] a, input logic [31:0] v, input string nm);
    if (sel == 3 || sel == 5) A2 = a; else A = a;
    lit_sel = sel; lit_val = v; lit_name = nm; lit_chk = 1'b1;
    tick(1);
    lit_chk = 1'b0;
  endtask

  logic [31:0] wrap_seq [9] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2,
                                32'd3, 32'd4, 32'd5, 32'd0};

  initial begin
    tick(3);
    rst_n = 1'b1;
    started = 1'b1;
    ex(0, 7'h00, 32'd0, "reset_ctrl0");
    ex(0, 7'h0C, 32'd0, "reset_cnt0");
    ex(0, 7'h40, 32'd0, "reset_status");
    ex(2, A, 32'd0, "reset_irq");

    // Ch0: PSC=3, CMP=4 -> match 20 cycles after the EN write, then every 20.
    wr(7'h04, 32'd3);
    wr(7'h08, 32'd4);
    wr(7'h00, 32'h1);
    A = 7'h40;
    tick(18);
    ex(0, 7'h40, 32'd0, "ch0_before_match_a");
    ex(0, 7'h40, 32'd0, "ch0_before_match_b");
    ex(0, 7'h40, 32'd1, "ch0_first_match");
    A = 7'h0C;
    tick(18);
    ex(0, 7'h0C, 32'd4, "ch0_cnt_at_cmp");
    ex(0, 7'h0C, 32'd0, "ch0_second_match");
    wr(7'h00, 32'h0);

    // Ch1: one-shot toggle with interrupt.
    wr(7'h18, 32'd2);
    wr(7'h44, 32'h2);
    wr(7'h10, 32'h7);
    tick(2);
    ex(1, A, 32'h0, "ch1_tout_pre");
    ex(1, A, 32'h2, "ch1_tout_toggled");
    ex(2, A, 32'h1, "ch1_irq_set");
    ex(0, 7'h10, 32'h6, "ch1_en_cleared");
    wr(7'h40, 32'h2);
    ex(2, A, 32'h1, "ch1_irq_lag");
    ex(2, A, 32'h0, "ch1_irq_cleared");
    tick(8);
    ex(1, A, 32'h2, "ch1_no_retoggle");

    // Ch2: counter wraps through 0xFFFFFFFF before matching at 5.
    wr(7'h28, 32'd5);
    wr(7'h24, 32'd0);
    wr(7'h2C, 32'hFFFF_FFFE);
    wr(7'h20, 32'h1);
    for (int i = 0; i < 9; i++) ex(0, 7'h2C, wrap_seq[i], "ch2_wrap_seq");
    ex(0, 7'h40, 32'h5, "ch2_status");
    wr(7'h20, 32'h0);
    wr(7'h40, 32'h4);
    wr(7'h40, 32'h0);
    ex(0, 7'h40, 32'h1, "status_write0_noop");

    // Ch0: W1C and CNT write each coincident with a match edge.
    wr(7'h0C, 32'd0);
    wr(7'h08, 32'd3);
    wr(7'h04, 32'd0);
    wr(7'h00, 32'h1);
    tick(3);
    wr(7'h40, 32'h1);
    ex(0, 7'h40, 32'h1, "set_beats_clear");
    wr(7'h40, 32'h1);
    tick(1);
    wr(7'h0C, 32'h10);
    ex(0, 7'h0C, 32'h10, "cnt_write_beats_match");
    ex(0, 7'h40, 32'h0, "cnt_write_no_flag");
    wr(7'h00, 32'h0);

    // Ch3 running with flags set, then asynchronous reset mid-cycle.
    wr(7'h3C, 32'd0);
    wr(7'h38, 32'd1);
    wr(7'h34, 32'd1);
    wr(7'h44, 32'hF);
    wr(7'h30, 32'h5);
    tick(6);
    ex(1, A, 32'hA, "tout_before_reset");
    ex(0, 7'h40, 32'h8, "status_before_reset");
    rst_n = 1'b0;
    lit_sel = 4; lit_val = '0; lit_name = "async_reset_outputs"; lit_chk = 1'b1;
    @(negedge clk);
    #1;
    lit_chk = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ex(0, 7'h40, 32'h0, "status_after_reset");
    ex(0, 7'h30, 32'h0, "ctrl3_after_reset");
    tick(10);
    ex(0, 7'h3C, 32'h0, "cnt3_idle_after_reset");
    ex(0, 7'h44, 32'h0, "irqen_after_reset");
    ex(1, A, 32'h0, "tout_after_reset");

    // N_CH=2 build: absent channels and upper STATUS/IRQEN bits read 0.
    ex(3, 7'h20, 32'h0, "n2_read_ch2");
    wr2(7'h30, 32'h5);
    ex(3, 7'h30, 32'h0, "n2_read_ch3");
    wr2(7'h44, 32'hF);
    ex(3, 7'h44, 32'h3, "n2_irqen_bits");
    wr2(7'h10, 32'h1);
    tick(3);
    ex(3, 7'h40, 32'h2, "n2_status_bits");
    ex(5, A2, 32'h1, "n2_irq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_timer_bank.md
PERIPHERAL_TIMER_BANK -- requirements
Module: peripheral_timer_bank

Interface
REQ-001 Parameter N_CH, default 4, number of timer channels (legal 1..4).
REQ-002 Parameter PSC_W, default 24, prescaler width in bits (legal 1..32).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 A  input  7  byte address within block: A[6]=0 channel space (ch=A[5:4], reg=A[3:2]), A[6]=1 global space.
REQ-006 WD  input  32  write data.
REQ-007 WE  input  1  write strobe, one write per cycle when high.
REQ-008 RD  output  32  read data, combinational from A.
REQ-009 tout  output  N_CH  per-channel toggle outputs, registered.
REQ-010 irq  output  1  interrupt request, registered, level.

Function
REQ-011 Channel regs: 0x0 CTRL {bit0 EN, bit1 ONESHOT, bit2 TOGGLE}, 0x4 PSC [PSC_W-1:0], 0x8 CMP [31:0], 0xC CNT [31:0]; unused bits read 0, writes ignored.
REQ-012 Global regs: 0x40 STATUS (bit i = match flag ch i, write-1-to-clear), 0x44 IRQEN (bit i enables ch i); bits >= N_CH read 0.
REQ-013 Reads of unmapped addresses, channels >= N_CH, or 0x48..0x7C SHALL return 0; writes there SHALL have no effect.
REQ-014 Prescaler: while EN=1, psc_cnt increments each cycle; when psc_cnt == PSC a tick is generated and psc_cnt returns to 0 (PSC=0 gives tick every cycle; PSC=k gives tick every k+1 cycles).
REQ-015 While EN=0, psc_cnt and CNT SHALL hold; setting EN SHALL restart psc_cnt from 0.
REQ-016 On tick: if CNT == CMP then match; else CNT <= CNT+1 with 32-bit wrap (0xFFFFFFFF -> 0).
REQ-017 On match: CNT <= 0, STATUS[i] <= 1, tout[i] toggles if TOGGLE=1; if ONESHOT=1, EN <= 0 in the same cycle.
REQ-018 Match period = (CMP+1)*(PSC+1) cycles; flag visible on RD the cycle after the match edge.
REQ-019 Write to CNT SHALL load WD and clear psc_cnt; it overrides a tick/match in the same cycle (no flag set).
REQ-020 Write to CTRL in the match cycle of a one-shot SHALL win over the hardware EN clear.
REQ-021 Write to PSC or CMP takes effect for the next comparison; psc_cnt is not cleared.
REQ-022 STATUS W1C coincident with a hardware set on the same bit: set wins (flag stays 1).
REQ-023 irq <= |(STATUS & IRQEN), one cycle after flag/enable change.
REQ-024 Writing 0 to STATUS bits SHALL have no effect.

Reset
REQ-025 On rst_n=0: CTRL, PSC, CMP, CNT, psc_cnt, STATUS, IRQEN = 0; tout = 0; irq = 0.
REQ-026 Reset mid-count SHALL abort all channels immediately; no match flag survives; operation resumes only after software re-enables.
REQ-027 RD SHALL read all-zero registers while and after reset until written.

Structure
REQ-028 Shared package peripheral_pkg holds register offsets (CTRL/PSC/CMP/CNT/STATUS/IRQEN), CTRL bit positions, and channel stride 16.
REQ-029 One sub-module timer_channel (prescaler, counter, compare, tout, match pulse), instantiated N_CH times via generate; top holds decode, STATUS, IRQEN, RD mux, irq.
REQ-030 Target 150-300 lines RTL total.

Verification
REQ-031 Ch0 PSC=3, CMP=4, CTRL=0x1 -> first match 20 cycles after EN write, then every 20 cycles; STATUS=0x1.
REQ-032 Ch1 PSC=0, CMP=2, CTRL=0x7, IRQEN=0x2 -> tout[1] toggles after 3 cycles, EN reads 0, irq=1; write STATUS=0x2 -> irq=0 next cycle, no further toggles.
REQ-033 Ch2 CNT write 0xFFFFFFFE, CMP=5, PSC=0, EN -> CNT reads 0xFFFFFFFF, 0, ..., match at 5 (wrap verified).
REQ-034 Ch0 match coincident with STATUS=0x1 write -> STATUS[0] remains 1; match coincident with CNT write 0x10 -> CNT=0x10, flag not set.
REQ-035 N_CH=2 build: read 0x20 and write/read 0x30 -> RD=0; STATUS bits 2-3 read 0.
REQ-036 rst_n pulsed low mid-count with flags set -> all registers, tout, irq = 0 asynchronously; no matches until re-enabled.
